// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-port SRAM arbiter.
package sram_arb_pkg;
    typedef enum logic {P_DATA, P_INST} prio_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} own_t;
    localparam int MAXSTALL_DEF = 4;
endpackage

// File: rtl/sram_arb_fair.sv
// Fetch starvation guard: after MAXSTALL contended LSU wins in a row, the
// next cycle favours the IFU.
module sram_arb_fair
    import sram_arb_pkg::*;
#(
    parameter int MAXSTALL = MAXSTALL_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_req,
    input  logic d_req,
    output logic prio_i
);
    localparam int SW = $clog2(MAXSTALL + 1);

    prio_t         state_q;
    logic [SW-1:0] stall_q;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q <= P_DATA;
            stall_q <= '0;
        end else begin
            case (state_q)
                P_DATA: begin
                    if (i_req && d_req) begin
                        if (stall_q == SW'(MAXSTALL - 1)) begin
                            state_q <= P_INST;
                            stall_q <= '0;
                        end else begin
                            stall_q <= stall_q + 1'b1;
                        end
                    end else begin
                        stall_q <= '0;
                    end
                end
                // One cycle of IFU priority: it is either used or i_req was low.
                P_INST: begin
                    state_q <= P_DATA;
                    stall_q <= '0;
                end
                default: begin
                    state_q <= P_DATA;
                    stall_q <= '0;
                end
            endcase
        end
    end

    assign prio_i = (state_q == P_INST);
endmodule

// File: rtl/sram_arb2.sv
// IFU/LSU arbiter for one single-port synchronous SRAM; LSU has priority,
// fetch starvation bounded by sram_arb_fair.
module sram_arb2
    import sram_arb_pkg::*;
#(
    parameter int AW       = 14,
    parameter int DW       = 32,
    parameter int MAXSTALL = MAXSTALL_DEF,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_req,
    input  logic [AW-1:0] i_a,
    input  logic          i_flush,
    output logic          i_gnt,
    output logic          i_rvld,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic [AW-1:0] d_a,
    input  logic [3:0]    d_we,
    input  logic [DW-1:0] d_wd,
    input  logic [3:0]    d_re,
    output logic          d_gnt,
    output logic          d_rvld,
    output logic [DW-1:0] d_rdata,
    output logic          m_e,
    output logic [AW-1:0] m_a,
    output logic [3:0]    m_we,
    output logic [DW-1:0] m_wd,
    input  logic [DW-1:0] m_rd,
    output logic [CW-1:0] conflict_cnt
);
    logic          prio_i;
    own_t          own_q, own_d;
    logic [CW-1:0] cnt_q;

    sram_arb_fair #(.MAXSTALL(MAXSTALL)) u_fair (
        .clk    (clk),
        .rstn   (rstn),
        .i_req  (i_req),
        .d_req  (d_req),
        .prio_i (prio_i)
    );

    // Grants are suppressed while reset is held.
    assign i_gnt = !rstn && i_req && (prio_i || !d_req);
    assign d_gnt = !rstn && d_req && !(prio_i && i_req);

    always_comb begin
        m_e  = 1'b0;
        m_a  = '0;
        m_we = '0;
        m_wd = '0;
        if (i_gnt) begin
            m_e = 1'b1;
            m_a = i_a;
        end else if (d_gnt) begin
            m_e  = 1'b1;
            m_a  = d_a;
            m_we = d_we;
            m_wd = d_wd;
        end
    end

    // A read that also writes owes no response.
    always_comb begin
        own_d = OWN_NONE;
        if (i_gnt)
            own_d = OWN_I;
        else if (d_gnt && (d_re != '0) && (d_we == '0))
            own_d = OWN_D;
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            own_q <= OWN_NONE;
            cnt_q <= '0;
        end else begin
            own_q <= own_d;
            if (i_req && d_req && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign i_rvld       = (own_q == OWN_I) && !i_flush;
    assign d_rvld       = (own_q == OWN_D);
    assign i_rdata      = m_rd;
    assign d_rdata      = m_rd;
    assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_sram_arb2.sv
// Randomized bench for sram_arb2 against a behavioural arbitration/SRAM model.
module tb_sram_arb2;
    localparam int AW = 14, DW = 32, MAXSTALL = 4, CW = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          i_req = 1'b0, i_flush = 1'b0, d_req = 1'b0;
    logic [AW-1:0] i_a = '0, d_a = '0;
    logic [3:0]    d_we = '0, d_re = '0;
    logic [DW-1:0] d_wd = '0;
    logic          i_gnt, i_rvld, d_gnt, d_rvld, m_e;
    logic [DW-1:0] i_rdata, d_rdata, m_wd;
    logic [DW-1:0] m_rd = '0;
    logic [AW-1:0] m_a;
    logic [3:0]    m_we;
    logic [CW-1:0] conflict_cnt;

    always #5 clk = ~clk;

    sram_arb2 #(.AW(AW), .DW(DW), .MAXSTALL(MAXSTALL), .CW(CW)) dut (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_a(i_a), .i_flush(i_flush), .i_gnt(i_gnt),
        .i_rvld(i_rvld), .i_rdata(i_rdata),
        .d_req(d_req), .d_a(d_a), .d_we(d_we), .d_wd(d_wd), .d_re(d_re),
        .d_gnt(d_gnt), .d_rvld(d_rvld), .d_rdata(d_rdata),
        .m_e(m_e), .m_a(m_a), .m_we(m_we), .m_wd(m_wd), .m_rd(m_rd),
        .conflict_cnt(conflict_cnt)
    );

    // SRAM: read returns the pre-write contents one cycle later.
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (m_e) begin
            m_rd <= mem[m_a];
            for (int b = 0; b < 4; b++)
                if (m_we[b]) mem[m_a][8*b +: 8] <= m_wd[8*b +: 8];
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    logic [DW-1:0] exp_rd;
    bit  fetch_owed;      // IFU is owed the next contended slot
    int  streak;          // consecutive contended LSU wins
    bit  owe_i, owe_d, eg_i, eg_d;
    int  conf;
    int  total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic cycle();
        #1;
        if (rstn) begin
            fetch_owed = 0; streak = 0; owe_i = 0; owe_d = 0; conf = 0;
        end
        eg_i = 0; eg_d = 0;
        if (!rstn) begin
            if (i_req && (!d_req || fetch_owed)) eg_i = 1;
            else if (d_req) eg_d = 1;
        end
        chk("i_gnt", i_gnt, eg_i);
        chk("d_gnt", d_gnt, eg_d);
        chk("m_e", m_e, eg_i || eg_d);
        chk("m_we", m_we, eg_d ? d_we : 4'h0);
        if (eg_i) chk("m_a_i", m_a, i_a);
        if (eg_d) begin
            chk("m_a_d", m_a, d_a);
            chk("m_wd", m_wd, d_wd);
        end
        chk("i_rvld", i_rvld, owe_i && !i_flush);
        chk("d_rvld", d_rvld, owe_d);
        if (owe_i && !i_flush) chk("i_rdata", i_rdata, exp_rd);
        if (owe_d) chk("d_rdata", d_rdata, exp_rd);
        chk("conflict", conflict_cnt, conf);
        if (!rstn) begin
            if (i_req && d_req && conf < (1 << CW) - 1) conf++;
            owe_i = eg_i;
            owe_d = eg_d && d_re != 0 && d_we == 0;
            if (eg_i) exp_rd = ref_mem[i_a];
            if (eg_d) begin
                exp_rd = ref_mem[d_a];
                for (int b = 0; b < 4; b++)
                    if (d_we[b]) ref_mem[d_a][8*b +: 8] = d_wd[8*b +: 8];
            end
            if (fetch_owed) begin
                fetch_owed = 0; streak = 0;
            end else if (eg_d && i_req) begin
                streak++;
                if (streak == MAXSTALL) begin fetch_owed = 1; streak = 0; end
            end else begin
                streak = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            logic [DW-1:0] v;
            v = $urandom;
            mem[k] = v;
            ref_mem[k] = v;
        end
        @(negedge clk);
        // Reset held with both requesting, then release: LSU wins first
        i_req = 1; d_req = 1; d_re = 4'hF; d_we = 0; i_a = 3; d_a = 7;
        repeat (2) cycle();
        rstn = 0;
        // Continuous contention: D,D,D,D,I pattern and conflict count
        repeat (15) cycle();
        // IFU-only back-to-back reads
        d_req = 0;
        for (int a = 0; a < 4; a++) begin
            i_a = AW'(a);
            cycle();
        end
        i_req = 0;
        cycle();
        // Partial write then fetch of the same word
        d_req = 1; d_a = 5; d_we = 4'b0011; d_wd = 32'hAABBCCDD; d_re = 0;
        cycle();
        d_req = 0; d_we = 0; i_req = 1; i_a = 5;
        cycle();
        chk("wr_lo", i_rdata[15:0], 16'hCCDD);
        i_req = 0;
        cycle();
        // Flush masks exactly one response
        i_req = 1; i_a = 9; cycle();
        i_a = 10; i_flush = 1; cycle();
        i_flush = 0; i_req = 0; cycle();
        // Reset right after an LSU read grant
        d_req = 1; d_re = 4'hF; d_a = 2; cycle();
        rstn = 1; d_req = 0; cycle();
        cycle();
        rstn = 0; cycle();
        // Random traffic; requests held until granted
        for (int n = 0; n < 600; n++) begin
            if (!(i_req && !eg_i)) begin
                i_req = ($urandom % 4) != 0;
                i_a = AW'($urandom_range(0, 15));
            end
            if (!(d_req && !eg_d)) begin
                d_req = ($urandom % 4) != 0;
                d_a = AW'($urandom_range(0, 15));
                d_we = (($urandom % 3) == 0) ? 4'($urandom) : 4'h0;
                d_re = 4'($urandom);
                d_wd = $urandom;
            end
            i_flush = ($urandom % 5) == 0;
            rstn = ($urandom % 60) == 0;
            cycle();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
